// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if: ID-stage decode inputs and pipelined control outputs of the pipeline control unit
interface pipe_control_unit_if #(
  parameter int REG_AW = 5,
  parameter int OPC_W = 6,
  parameter int ALUOP_W = 2
);
  logic [OPC_W-1:0] Opcode;
  logic [REG_AW-1:0] IdRs, IdRt, IdRd;
  logic BranchTaken;
  logic Stall, FlushIfId, IdJump;
  logic ExRegDst, ExALUSrc, ExSignZero, ExBranch, ExBranchEq;
  logic [ALUOP_W-1:0] ExALUOp;
  logic MemMemRead, MemMemWrite;
  logic WbMemtoReg, WbRegWrite;
  logic [REG_AW-1:0] WbDestReg;
  logic [1:0] ForwardA, ForwardB;
  modport master (
    output Opcode, IdRs, IdRt, IdRd, BranchTaken,
    input Stall, FlushIfId, IdJump, ExRegDst, ExALUSrc, ExSignZero, ExBranch, ExBranchEq,
    input ExALUOp, MemMemRead, MemMemWrite, WbMemtoReg, WbRegWrite, WbDestReg, ForwardA, ForwardB
  );
  modport slave (
    input Opcode, IdRs, IdRt, IdRd, BranchTaken,
    output Stall, FlushIfId, IdJump, ExRegDst, ExALUSrc, ExSignZero, ExBranch, ExBranchEq,
    output ExALUOp, MemMemRead, MemMemWrite, WbMemtoReg, WbRegWrite, WbDestReg, ForwardA, ForwardB
  );
endinterface

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: 5-stage MIPS control with ID decode, pipelined control bits, hazard stall, flush and forwarding
module pipe_control_unit #(
  parameter int REG_AW = 5,
  parameter int OPC_W = 6,
  parameter int ALUOP_W = 2,
  parameter bit FWD_EN = 1'b1
) (
  input logic clk,
  input logic reset_n,
  pipe_control_unit_if.slave bus
);
  localparam logic [OPC_W-1:0] OP_R = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BNE = OPC_W'(6'b000101);
  localparam logic [OPC_W-1:0] OP_BEQ = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_XORI = OPC_W'(6'b001110);
  localparam logic [OPC_W-1:0] OP_J = OPC_W'(6'b000010);

  typedef struct packed {
    logic reg_dst, alu_src, sign_zero, branch, branch_eq;
    logic [ALUOP_W-1:0] alu_op;
    logic mem_read, mem_write, mem_to_reg, reg_write;
  } ctrl_t;

  typedef struct packed {
    ctrl_t c;
    logic [REG_AW-1:0] dest, rs, rt;
  } idex_t;

  typedef struct packed {
    logic mem_read, mem_write, mem_to_reg, reg_write;
    logic [REG_AW-1:0] dest;
  } exmem_t;

  typedef struct packed {
    logic mem_to_reg, reg_write;
    logic [REG_AW-1:0] dest;
  } memwb_t;

  ctrl_t dec;
  logic jump, rt_src, taken, stall, id_jump;
  logic [REG_AW-1:0] dest;
  idex_t id_next, ex;
  exmem_t mem;
  memwb_t wb;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src, input exmem_t m, input memwb_t w);
    return (m.reg_write && m.dest != '0 && m.dest == src) ? 2'b10 :
           (w.reg_write && w.dest != '0 && w.dest == src) ? 2'b01 : 2'b00;
  endfunction

  // ID-stage main decoder; unknown opcodes decode to an all-zero bubble
  always_comb begin
    dec = '0;
    jump = 1'b0;
    rt_src = 1'b0;
    case (bus.Opcode)
      OP_R: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(2); rt_src = 1'b1; end
      OP_LW: begin dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1; end
      OP_SW: begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; rt_src = 1'b1; end
      OP_BNE: begin dec.branch = 1'b1; dec.alu_op = ALUOP_W'(1); rt_src = 1'b1; end
      OP_BEQ: begin dec.branch = 1'b1; dec.branch_eq = 1'b1; dec.alu_op = ALUOP_W'(1); rt_src = 1'b1; end
      OP_ADDI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      OP_XORI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(3); dec.sign_zero = 1'b1; end
      OP_J: jump = 1'b1;
      default: ;
    endcase
  end

  assign dest = dec.reg_dst ? bus.IdRd : bus.IdRt;

  // ID/EX candidate; writes to $0 are dropped here so later stages never see them
  always_comb begin
    id_next = '0;
    id_next.c = dec;
    id_next.c.reg_write = dec.reg_write & (dest != '0);
    id_next.dest = dest;
    id_next.rs = bus.IdRs;
    id_next.rt = bus.IdRt;
  end

  assign taken = bus.BranchTaken & ex.c.branch;
  assign stall = !taken && ex.c.mem_read && ex.dest != '0 &&
                 (ex.dest == bus.IdRs || (ex.dest == bus.IdRt && rt_src));
  assign id_jump = jump & !taken & !stall;

  // ID/EX: decoded instruction, or a bubble on taken branch, load-use stall or jump
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ex <= '0;
    else ex <= (taken || stall || id_jump) ? '0 : id_next;

  // EX/MEM and MEM/WB always advance
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem <= '0;
      wb <= '0;
    end else begin
      mem <= '{ex.c.mem_read, ex.c.mem_write, ex.c.mem_to_reg, ex.c.reg_write, ex.dest};
      wb <= '{mem.mem_to_reg, mem.reg_write, mem.dest};
    end

  assign bus.Stall = stall;
  assign bus.IdJump = id_jump;
  assign bus.FlushIfId = taken | id_jump;
  assign bus.ExRegDst = ex.c.reg_dst;
  assign bus.ExALUSrc = ex.c.alu_src;
  assign bus.ExSignZero = ex.c.sign_zero;
  assign bus.ExBranch = ex.c.branch;
  assign bus.ExBranchEq = ex.c.branch_eq;
  assign bus.ExALUOp = ex.c.alu_op;
  assign bus.MemMemRead = mem.mem_read;
  assign bus.MemMemWrite = mem.mem_write;
  assign bus.WbMemtoReg = wb.mem_to_reg;
  assign bus.WbRegWrite = wb.reg_write;
  assign bus.WbDestReg = wb.dest;

  if (FWD_EN) begin : g_fwd
    assign bus.ForwardA = fwd_sel(ex.rs, mem, wb);
    assign bus.ForwardB = fwd_sel(ex.rt, mem, wb);
  end else begin : g_nofwd
    assign bus.ForwardA = 2'b00;
    assign bus.ForwardB = 2'b00;
  end
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: table vectors, reset sequences and a randomized run against a stage-queue model
module tb_pipe_control_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_control_unit_if bus ();
  pipe_control_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic rd_sel, alu_src, sz, br, beq;
    logic [1:0] op;
    logic mr, mw, m2r, rw, jmp, rt_src;
    logic [4:0] dest, rs, rt;
  } ins_t;

  typedef struct {
    logic [5:0] opc;
    logic [4:0] rs, rt, rd;
    logic bt;
    logic st, fl, jp, src;
    logic [1:0] op;
    logic br, mmr, wrw;
    logic [4:0] wd;
    logic [1:0] fa, fb;
  } vec_t;

  ins_t ex_s, mem_s, wb_s;
  vec_t tbl [11];
  logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000101,
                          6'b000100, 6'b001000, 6'b001110, 6'b000010};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t decode(input logic [5:0] opc, input logic [4:0] rs, rt, rd);
    ins_t d;
    d = '0;
    case (opc)
      6'b000000: begin d.rd_sel = 1'b1; d.rw = 1'b1; d.op = 2'b10; d.rt_src = 1'b1; end
      6'b100011: begin d.alu_src = 1'b1; d.m2r = 1'b1; d.rw = 1'b1; d.mr = 1'b1; end
      6'b101011: begin d.alu_src = 1'b1; d.mw = 1'b1; d.rt_src = 1'b1; end
      6'b000101: begin d.br = 1'b1; d.op = 2'b01; d.rt_src = 1'b1; end
      6'b000100: begin d.br = 1'b1; d.beq = 1'b1; d.op = 2'b01; d.rt_src = 1'b1; end
      6'b001000: begin d.alu_src = 1'b1; d.rw = 1'b1; end
      6'b001110: begin d.alu_src = 1'b1; d.rw = 1'b1; d.op = 2'b11; d.sz = 1'b1; end
      6'b000010: d.jmp = 1'b1;
      default: ;
    endcase
    d.rs = rs;
    d.rt = rt;
    d.dest = d.rd_sel ? rd : rt;
    if (d.dest == 5'd0) d.rw = 1'b0;
    return d;
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] src);
    if (mem_s.rw && mem_s.dest != 5'd0 && mem_s.dest == src) return 2'b10;
    if (wb_s.rw && wb_s.dest != 5'd0 && wb_s.dest == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input logic [5:0] opc, input logic [4:0] rs, rt, rd, input logic bt);
    bus.Opcode = opc;
    bus.IdRs = rs;
    bus.IdRt = rt;
    bus.IdRd = rd;
    bus.BranchTaken = bt;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " Stall"}, 8'(bus.Stall), 8'd0);
    chk({tag, " FlushIfId"}, 8'(bus.FlushIfId), 8'd0);
    chk({tag, " IdJump"}, 8'(bus.IdJump), 8'd0);
    chk({tag, " ExRegDst"}, 8'(bus.ExRegDst), 8'd0);
    chk({tag, " ExALUSrc"}, 8'(bus.ExALUSrc), 8'd0);
    chk({tag, " ExSignZero"}, 8'(bus.ExSignZero), 8'd0);
    chk({tag, " ExBranch"}, 8'(bus.ExBranch), 8'd0);
    chk({tag, " ExBranchEq"}, 8'(bus.ExBranchEq), 8'd0);
    chk({tag, " ExALUOp"}, 8'(bus.ExALUOp), 8'd0);
    chk({tag, " MemMemRead"}, 8'(bus.MemMemRead), 8'd0);
    chk({tag, " MemMemWrite"}, 8'(bus.MemMemWrite), 8'd0);
    chk({tag, " WbMemtoReg"}, 8'(bus.WbMemtoReg), 8'd0);
    chk({tag, " WbRegWrite"}, 8'(bus.WbRegWrite), 8'd0);
    chk({tag, " WbDestReg"}, 8'(bus.WbDestReg), 8'd0);
    chk({tag, " ForwardA"}, 8'(bus.ForwardA), 8'd0);
    chk({tag, " ForwardB"}, 8'(bus.ForwardB), 8'd0);
  endtask

  task automatic step(input logic [5:0] opc, input logic [4:0] rs, rt, rd, input logic bt);
    ins_t d;
    logic taken, stall, jmp;
    drive(opc, rs, rt, rd, bt);
    #1;
    d = decode(opc, rs, rt, rd);
    taken = bt && ex_s.br;
    stall = !taken && ex_s.mr && ex_s.dest != 5'd0 && (ex_s.dest == rs || (ex_s.dest == rt && d.rt_src));
    jmp = d.jmp && !taken && !stall;
    chk("Stall", 8'(bus.Stall), 8'(stall));
    chk("FlushIfId", 8'(bus.FlushIfId), 8'(taken || jmp));
    chk("IdJump", 8'(bus.IdJump), 8'(jmp));
    chk("ExRegDst", 8'(bus.ExRegDst), 8'(ex_s.rd_sel));
    chk("ExALUSrc", 8'(bus.ExALUSrc), 8'(ex_s.alu_src));
    chk("ExSignZero", 8'(bus.ExSignZero), 8'(ex_s.sz));
    chk("ExBranch", 8'(bus.ExBranch), 8'(ex_s.br));
    chk("ExBranchEq", 8'(bus.ExBranchEq), 8'(ex_s.beq));
    chk("ExALUOp", 8'(bus.ExALUOp), 8'(ex_s.op));
    chk("MemMemRead", 8'(bus.MemMemRead), 8'(mem_s.mr));
    chk("MemMemWrite", 8'(bus.MemMemWrite), 8'(mem_s.mw));
    chk("WbMemtoReg", 8'(bus.WbMemtoReg), 8'(wb_s.m2r));
    chk("WbRegWrite", 8'(bus.WbRegWrite), 8'(wb_s.rw));
    chk("WbDestReg", 8'(bus.WbDestReg), 8'(wb_s.dest));
    chk("ForwardA", 8'(bus.ForwardA), 8'(fwd(ex_s.rs)));
    chk("ForwardB", 8'(bus.ForwardB), 8'(fwd(ex_s.rt)));
    wb_s = mem_s;
    mem_s = ex_s;
    ex_s = (taken || stall || jmp) ? '0 : d;
    @(negedge clk);
  endtask

  initial begin
    int k;
    logic [5:0] opc;
    tbl[0] = '{6'b100011, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0};
    tbl[1] = '{6'b000000, 5'd8, 5'd0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0};
    tbl[2] = '{6'b000000, 5'd8, 5'd0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 2'd0};
    tbl[3] = '{6'b000000, 5'd10, 5'd10, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 2'd0};
    tbl[4] = '{6'b000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 2'd2, 2'd2};
    tbl[5] = '{6'b000101, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 5'd10, 2'd0, 2'd0};
    tbl[6] = '{6'b100011, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 5'd11, 2'd0, 2'd0};
    tbl[7] = '{6'b000101, 5'd4, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0};
    tbl[8] = '{6'b000000, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 5'd2, 2'd0, 2'd0};
    tbl[9] = '{6'b000010, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd0, 2'd0};
    tbl[10] = '{6'b001110, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd5, 2'd0, 2'd0};
    drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].opc, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].bt);
      #1;
      chk($sformatf("row%0d Stall", i), 8'(bus.Stall), 8'(tbl[i].st));
      chk($sformatf("row%0d FlushIfId", i), 8'(bus.FlushIfId), 8'(tbl[i].fl));
      chk($sformatf("row%0d IdJump", i), 8'(bus.IdJump), 8'(tbl[i].jp));
      chk($sformatf("row%0d ExALUSrc", i), 8'(bus.ExALUSrc), 8'(tbl[i].src));
      chk($sformatf("row%0d ExALUOp", i), 8'(bus.ExALUOp), 8'(tbl[i].op));
      chk($sformatf("row%0d ExBranch", i), 8'(bus.ExBranch), 8'(tbl[i].br));
      chk($sformatf("row%0d MemMemRead", i), 8'(bus.MemMemRead), 8'(tbl[i].mmr));
      chk($sformatf("row%0d WbRegWrite", i), 8'(bus.WbRegWrite), 8'(tbl[i].wrw));
      chk($sformatf("row%0d WbDestReg", i), 8'(bus.WbDestReg), 8'(tbl[i].wd));
      chk($sformatf("row%0d ForwardA", i), 8'(bus.ForwardA), 8'(tbl[i].fa));
      chk($sformatf("row%0d ForwardB", i), 8'(bus.ForwardB), 8'(tbl[i].fb));
      @(negedge clk);
    end
    drive(6'b100011, 5'd0, 5'd8, 5'd0, 1'b0);
    @(negedge clk);
    drive(6'b000000, 5'd8, 5'd0, 5'd10, 1'b0);
    #1;
    chk("midstall Stall", 8'(bus.Stall), 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    ex_s = '0;
    mem_s = '0;
    wb_s = '0;
    step(6'b100011, 5'd0, 5'd8, 5'd0, 1'b0);
    #1;
    chk("lw ExALUSrc", 8'(bus.ExALUSrc), 8'd1);
    chk("lw ExALUOp", 8'(bus.ExALUOp), 8'd0);
    step(6'b000000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("lw MemMemRead", 8'(bus.MemMemRead), 8'd1);
    step(6'b000000, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("lw WbMemtoReg", 8'(bus.WbMemtoReg), 8'd1);
    chk("lw WbRegWrite", 8'(bus.WbRegWrite), 8'd1);
    chk("lw WbDestReg", 8'(bus.WbDestReg), 8'd8);
    for (int n = 0; n < 600; n++) begin
      if (n % 97 == 96) begin
        drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero("random reset");
        @(negedge clk);
        reset_n = 1'b1;
        ex_s = '0;
        mem_s = '0;
        wb_s = '0;
      end
      k = $urandom_range(0, 8);
      opc = (k == 8) ? 6'($urandom) : ops[k];
      step(opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
